// File: rtl/sum_of_squares_pkg.sv
// ============================================================================
// Module      : sum_of_squares_pkg
// Description : Shared widths, FSM state encoding and magnitude clamp helper
//               for the serial sum-of-squares front-end.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sum_of_squares_pkg;

    localparam int C_IN_W  = 11;
    localparam int C_MAG_W = 10;
    localparam int C_OUT_W = 21;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SQ_X = 2'd1,
        ST_SQ_Y = 2'd2,
        ST_DONE = 2'd3
    } sos_state_t;

    // |v| saturated to the largest MAG_W-bit value; the extra bit keeps -2^(IN_W-1) exact
    function automatic logic [C_MAG_W-1:0] clamp_abs(input logic signed [C_IN_W-1:0] v);
        logic [C_IN_W:0]    mag;
        logic [C_MAG_W-1:0] mag_max;
        mag_max = '1;
        mag     = v[C_IN_W-1] ? (~{v[C_IN_W-1], v} + 1'b1) : {1'b0, v};
        if (mag > {{(C_IN_W+1-C_MAG_W){1'b0}}, mag_max})
            return mag_max;
        else
            return mag[C_MAG_W-1:0];
    endfunction

endpackage

`default_nettype wire

// File: rtl/sum_of_squares_serial_squarer.sv
// ============================================================================
// Module      : serial_squarer
// Description : LSB-first shift-add squarer adding into an external accumulator.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_squarer
    import sum_of_squares_pkg::*;
#(
    parameter int MAG_W = C_MAG_W,
    parameter int OUT_W = C_OUT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [MAG_W-1:0] i_operand,
    input  logic             i_step,
    input  logic [OUT_W-1:0] i_acc,
    output logic [OUT_W-1:0] o_acc_next,
    output logic             o_done
);

    localparam int CNT_W = $clog2(MAG_W);
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(MAG_W - 1);

    logic [MAG_W-1:0] r_operand;
    logic [CNT_W-1:0] r_count;
    logic [OUT_W-1:0] w_shifted;

    // Load wins over step so the second operand can be queued on the last step edge
    always_ff @(posedge clk) begin
        if (rst) begin
            r_operand <= '0;
            r_count   <= '0;
        end else if (i_load) begin
            r_operand <= i_operand;
            r_count   <= '0;
        end else if (i_step) begin
            r_count   <= (r_count == C_LAST) ? '0 : r_count + 1'b1;
        end
    end

    assign w_shifted  = OUT_W'(r_operand) << r_count;
    assign o_acc_next = i_acc + (r_operand[r_count] ? w_shifted : '0);
    assign o_done     = i_step && (r_count == C_LAST);

endmodule

`default_nettype wire

// File: rtl/sum_of_squares.sv
// ============================================================================
// Module      : sum_of_squares
// Description : Handshaked dx^2 + dy^2 using one shared serial squarer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sum_of_squares
    import sum_of_squares_pkg::*;
#(
    parameter int IN_W  = C_IN_W,
    parameter int MAG_W = C_MAG_W,
    parameter int OUT_W = C_OUT_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic signed [IN_W-1:0] dx,
    input  logic signed [IN_W-1:0] dy,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [OUT_W-1:0]       sum
);

    sos_state_t       r_state;
    sos_state_t       w_state_next;
    logic [MAG_W-1:0] r_mag_y;
    logic [OUT_W-1:0] r_acc;
    logic [OUT_W-1:0] w_acc_next;
    logic             w_accept;
    logic             w_step;
    logic             w_done;
    logic             w_load;
    logic [MAG_W-1:0] w_operand;

    assign w_accept  = in_valid && (r_state == ST_IDLE);
    assign w_step    = (r_state == ST_SQ_X) || (r_state == ST_SQ_Y);
    assign w_load    = w_accept || ((r_state == ST_SQ_X) && w_done);
    assign w_operand = w_accept ? clamp_abs(dx) : r_mag_y;

    always_ff @(posedge clk) begin
        if (rst)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (in_valid)  w_state_next = ST_SQ_X;
            ST_SQ_X: if (w_done)    w_state_next = ST_SQ_Y;
            ST_SQ_Y: if (w_done)    w_state_next = ST_DONE;
            ST_DONE: if (out_ready) w_state_next = ST_IDLE;
            default:                w_state_next = ST_IDLE;
        endcase
    end

    // Handshake flags decode straight from the state register
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (r_state)
            ST_IDLE: in_ready  = 1'b1;
            ST_DONE: out_valid = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc   <= '0;
            r_mag_y <= '0;
        end else if (w_accept) begin
            r_acc   <= '0;
            r_mag_y <= clamp_abs(dy);
        end else if (w_step) begin
            r_acc   <= w_acc_next;
        end
    end

    serial_squarer #(
        .MAG_W (MAG_W),
        .OUT_W (OUT_W)
    ) u_squarer (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_load),
        .i_operand  (w_operand),
        .i_step     (w_step),
        .i_acc      (r_acc),
        .o_acc_next (w_acc_next),
        .o_done     (w_done)
    );

    assign sum = r_acc;

endmodule

`default_nettype wire

// File: tb/tb_sum_of_squares.sv
// ============================================================================
// Module      : tb_sum_of_squares
// Description : Self-checking bench for sum_of_squares.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sum_of_squares;

    logic               clk = 1'b0;
    logic               rst;
    logic               in_valid;
    logic               in_ready;
    logic signed [10:0] dx;
    logic signed [10:0] dy;
    logic               out_valid;
    logic               out_ready;
    logic [20:0]        sum;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic signed [10:0] dx;
        logic signed [10:0] dy;
        int                 exp;
        string              name;
    } vec_t;

    vec_t vecs[7];

    sum_of_squares dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dx        (dx),
        .dy        (dy),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum)
    );

    always #5 clk = ~clk;

    function automatic int ref_sum(input int x, input int y);
        int ax;
        int ay;
        ax = (x < 0) ? -x : x;
        ay = (y < 0) ? -y : y;
        if (ax > 1023) ax = 1023;
        if (ay > 1023) ay = 1023;
        return ax * ax + ay * ay;
    endfunction

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Present one pair with out_ready high; checks latency, result and return to IDLE
    task automatic run_pair(input logic signed [10:0] x, input logic signed [10:0] y,
                            input int exp, input string name);
        int n;
        int lat;
        @(negedge clk);
        in_valid = 1'b1;
        dx = x;
        dy = y;
        n = 0;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check({name, " accept_timeout"}, (n < 100) ? 1 : 0, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        dx = 11'($urandom);
        dy = 11'($urandom);
        lat = 0;
        while (lat < 100) begin
            @(posedge clk);
            lat++;
            #1;
            if (out_valid) break;
        end
        check({name, " latency"}, lat, 20);
        check({name, " sum"}, sum, exp);
        @(posedge clk);
        #1;
        check({name, " in_ready_back"}, {in_ready, out_valid}, 2'b10);
    endtask

    initial begin
        vecs[0] = '{dx: 11'sd3,     dy: 11'sd4,     exp: 25,      name: "basic_3_4"};
        vecs[1] = '{dx: -11'sd1024, dy: -11'sd1024, exp: 2093058, name: "clamp_min_min"};
        vecs[2] = '{dx: 11'sd1023,  dy: 11'sd0,     exp: 1046529, name: "max_pos"};
        vecs[3] = '{dx: -11'sd1,    dy: 11'sd0,     exp: 1,       name: "neg_one"};
        vecs[4] = '{dx: 11'sd0,     dy: 11'sd0,     exp: 0,       name: "zero"};
        vecs[5] = '{dx: 11'sd0,     dy: -11'sd1024, exp: 1046529, name: "clamp_y"};
        vecs[6] = '{dx: -11'sd300,  dy: 11'sd517,   exp: 357289,  name: "mixed"};

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        dx        = '0;
        dy        = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset_flags", {in_ready, out_valid}, 2'b10);
        check("reset_sum", sum, 0);

        for (int i = 0; i < 7; i++)
            run_pair(vecs[i].dx, vecs[i].dy, vecs[i].exp, vecs[i].name);

        for (int i = 0; i < 12; i++) begin
            logic signed [10:0] rx;
            logic signed [10:0] ry;
            rx = 11'($urandom_range(0, 2047));
            ry = 11'($urandom_range(0, 2047));
            run_pair(rx, ry, ref_sum(int'(rx), int'(ry)), $sformatf("rand%0d", i));
        end

        // Backpressure: result must hold and new requests must be ignored
        begin
            int lat;
            out_ready = 1'b0;
            @(negedge clk);
            in_valid = 1'b1;
            dx = -11'sd5;
            dy = 11'sd12;
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            lat = 0;
            while (lat < 100) begin
                @(posedge clk);
                lat++;
                #1;
                if (out_valid) break;
            end
            check("bp latency", lat, 20);
            for (int k = 0; k < 7; k++) begin
                in_valid = 1'b1;
                dx = 11'sd1;
                dy = 11'sd1;
                @(posedge clk);
                #1;
                check($sformatf("bp hold%0d sum", k), sum, 169);
                check($sformatf("bp hold%0d flags", k), {in_ready, out_valid}, 2'b01);
            end
            out_ready = 1'b1;
            in_valid  = 1'b0;
            @(posedge clk);
            #1;
            check("bp release flags", {in_ready, out_valid}, 2'b10);
            check("bp release sum", sum, 169);
            run_pair(11'sd1, 11'sd1, 2, "bp represent");
        end

        // Reset eight cycles into the second square
        begin
            @(negedge clk);
            in_valid = 1'b1;
            dx = 11'sd100;
            dy = -11'sd50;
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            repeat (18) @(posedge clk);
            #1;
            check("pre_reset no valid", out_valid, 0);
            rst = 1'b1;
            @(posedge clk);
            #1;
            rst = 1'b0;
            check("mid_reset flags", {in_ready, out_valid}, 2'b10);
            check("mid_reset sum", sum, 0);
            run_pair(11'sd6, 11'sd8, 100, "after_reset");
        end

        // Back-to-back with in_valid held high
        begin
            int acc_cyc[2];
            int res[2];
            int nacc;
            int nres;
            nacc = 0;
            nres = 0;
            @(negedge clk);
            in_valid = 1'b1;
            dx = 11'sd7;
            dy = 11'sd24;
            for (int c = 0; c < 120 && nres < 2; c++) begin
                if (c > 0) @(negedge clk);
                if (in_valid && in_ready && nacc < 2) begin
                    acc_cyc[nacc] = c;
                    nacc++;
                end
                if (out_valid) begin
                    res[nres] = int'(sum);
                    nres++;
                end
                @(posedge clk);
                #1;
                if (nacc == 1) begin
                    dx = 11'sd20;
                    dy = 11'sd21;
                end
                if (nacc == 2) in_valid = 1'b0;
            end
            check("b2b accepts", nacc, 2);
            check("b2b results", nres, 2);
            if (nacc == 2) check("b2b spacing", acc_cyc[1] - acc_cyc[0], 22);
            if (nres == 2) begin
                check("b2b sum0", res[0], 625);
                check("b2b sum1", res[1], 841);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
